// File: rtl/button_handshake_responder.sv
// Debounced push-button responder: toggles a press flag (and captures the
// switches) on each accepted press, toggles a release flag on each accepted
// release. The two flags differ exactly while the button is held.
module button_handshake_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DATA_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic [DATA_WIDTH-1:0] switches,
  output logic                  subiu,
  output logic                  desceu,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  // With a single-sample window the wait states are skipped entirely.
  localparam logic SINGLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_t;

  logic                  r_sync1;
  logic                  r_sync2;
  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic                  r_subiu;
  logic                  r_desceu;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_pressed;

  state_t                w_state;
  logic [CNT_W-1:0]      w_count;
  logic                  w_accept_press;
  logic                  w_accept_release;
  logic                  w_subiu;
  logic                  w_desceu;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_pressed;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= CNT_ZERO;
      r_subiu   <= 1'b0;
      r_desceu  <= 1'b0;
      r_data    <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      r_subiu   <= w_subiu;
      r_desceu  <= w_desceu;
      r_data    <= w_data;
      r_pressed <= w_pressed;
    end
  end

  // Debounce FSM: any opposite sample aborts a pending wait and clears count.
  always_comb begin
    w_state          = r_state;
    w_count          = r_count;
    w_accept_press   = 1'b0;
    w_accept_release = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (r_sync2) begin
          if (SINGLE) begin
            w_state        = ST_HELD;
            w_count        = CNT_ZERO;
            w_accept_press = 1'b1;
          end else begin
            w_state = ST_PRESS_WAIT;
            w_count = CNT_ONE;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state = ST_IDLE;
          w_count = CNT_ZERO;
        end else if (r_count == CNT_LAST) begin
          w_state        = ST_HELD;
          w_count        = CNT_ZERO;
          w_accept_press = 1'b1;
        end else begin
          w_count = r_count + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!r_sync2) begin
          if (SINGLE) begin
            w_state          = ST_IDLE;
            w_count          = CNT_ZERO;
            w_accept_release = 1'b1;
          end else begin
            w_state = ST_RELEASE_WAIT;
            w_count = CNT_ONE;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state = ST_HELD;
          w_count = CNT_ZERO;
        end else if (r_count == CNT_LAST) begin
          w_state          = ST_IDLE;
          w_count          = CNT_ZERO;
          w_accept_release = 1'b1;
        end else begin
          w_count = r_count + CNT_ONE;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_count = CNT_ZERO;
      end
    endcase

    w_subiu   = w_accept_press   ? ~r_subiu  : r_subiu;
    w_desceu  = w_accept_release ? ~r_desceu : r_desceu;
    w_data    = w_accept_press   ? switches  : r_data;
    w_pressed = (w_state == ST_HELD) || (w_state == ST_RELEASE_WAIT);
  end

  assign subiu    = r_subiu;
  assign desceu   = r_desceu;
  assign data_out = r_data;
  assign pressed  = r_pressed;

endmodule

// File: tb/tb_button_handshake_responder.sv
// Scoreboard bench for button_handshake_responder (DEBOUNCE_CYCLES=4, 16-bit).
module tb_button_handshake_responder;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [7:0]    lat;
    logic          s;
    logic          d;
    logic          p;
    logic [DW-1:0] data;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          button = 1'b0;
  logic [DW-1:0] switches = '0;
  logic          subiu;
  logic          desceu;
  logic [DW-1:0] data_out;
  logic          pressed;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic done  = 1'b0;

  button_handshake_responder #(.DEBOUNCE_CYCLES(4), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .switches (switches),
    .subiu    (subiu),
    .desceu   (desceu),
    .data_out (data_out),
    .pressed  (pressed)
  );

  always #5 clk = ~clk;

  // Continuous handshake invariant and single-toggle-per-edge checks.
  logic prev_s = 1'b0;
  logic prev_d = 1'b0;
  always @(negedge clk) begin
    if (!done) begin
      n_cmp++;
      if ((subiu != desceu) !== pressed) begin
        n_err++;
        $display("FAIL invariant t=%0t: subiu=%b desceu=%b pressed=%b", $time, subiu, desceu, pressed);
      end
      n_cmp++;
      if ((subiu !== prev_s) && (desceu !== prev_d)) begin
        n_err++;
        $display("FAIL both_toggle t=%0t: subiu %b->%b desceu %b->%b", $time, prev_s, subiu, prev_d, desceu);
      end
      prev_s = subiu;
      prev_d = desceu;
    end
  end

  // Count posedges until a flag changes; 0 means no change within the budget.
  task automatic wait_flag_change(input int max_edges, output int edges);
    logic ps, pd;
    ps = subiu;
    pd = desceu;
    edges = 0;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (subiu !== ps || desceu !== pd) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    obs_t obs, exp;
    #3;
    exp = '{lat: 8'd0, s: 1'b0, d: 1'b0, p: 1'b0, data: '0};
    obs = '{lat: 8'd0, s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", obs, exp);
    end
    button = 1'b1;
    switches = 16'h1357;
    repeat (6) @(posedge clk);
    #1;
    obs = '{lat: 8'd0, s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_hold_button: got %h expected %h", obs, exp);
    end
    button = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_press();
    obs_t obs, exp;
    int e;
    @(negedge clk);
    switches = 16'h00A5;
    button = 1'b1;
    sb.push_back('{lat: 8'd6, s: 1'b1, d: 1'b0, p: 1'b1, data: 16'h00A5});
    wait_flag_change(20, e);
    exp = sb.pop_front();
    obs = '{lat: 8'(e), s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL press: got lat=%0d s=%b d=%b p=%b data=%h expected lat=%0d s=%b d=%b p=%b data=%h",
               obs.lat, obs.s, obs.d, obs.p, obs.data, exp.lat, exp.s, exp.d, exp.p, exp.data);
    end
    // switches move while held: captured value must not follow
    @(negedge clk);
    switches = 16'hFFFF;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (data_out !== 16'h00A5) begin
      n_err++;
      $display("FAIL data_hold_while_held: got %h expected %h", data_out, 16'h00A5);
    end
  endtask

  task automatic test_release(input string name, input logic es, input logic ed,
                              input logic [DW-1:0] edata);
    obs_t obs, exp;
    int e;
    @(negedge clk);
    button = 1'b0;
    sb.push_back('{lat: 8'd6, s: es, d: ed, p: 1'b0, data: edata});
    wait_flag_change(20, e);
    exp = sb.pop_front();
    obs = '{lat: 8'(e), s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got lat=%0d s=%b d=%b p=%b data=%h expected lat=%0d s=%b d=%b p=%b data=%h",
               name, obs.lat, obs.s, obs.d, obs.p, obs.data, exp.lat, exp.s, exp.d, exp.p, exp.data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch();
    obs_t obs, exp;
    int e;
    // three-cycle pulse is one sample short of acceptance
    @(negedge clk);
    switches = 16'h4321;
    sb.push_back('{lat: 8'd0, s: subiu, d: desceu, p: 1'b0, data: data_out});
    fork
      begin
        button = 1'b1;
        repeat (3) @(negedge clk);
        button = 1'b0;
      end
      wait_flag_change(15, e);
    join
    exp = sb.pop_front();
    obs = '{lat: 8'(e), s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL glitch_reject: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_bounce();
    obs_t obs, exp;
    int e;
    @(negedge clk);
    switches = 16'h1234;
    sb.push_back('{lat: 8'd9, s: 1'b0, d: 1'b1, p: 1'b1, data: 16'h1234});
    fork
      begin
        button = 1'b1;
        repeat (2) @(negedge clk);
        button = 1'b0;
        @(negedge clk);
        button = 1'b1;
      end
      wait_flag_change(20, e);
    join
    exp = sb.pop_front();
    obs = '{lat: 8'(e), s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL bounce_press: got lat=%0d s=%b d=%b p=%b data=%h expected lat=%0d s=%b d=%b p=%b data=%h",
               obs.lat, obs.s, obs.d, obs.p, obs.data, exp.lat, exp.s, exp.d, exp.p, exp.data);
    end
  endtask

  task automatic test_reset_mid_press();
    obs_t obs, exp;
    int e;
    @(negedge clk);
    switches = 16'hBEEF;
    button = 1'b1;
    sb.push_back('{lat: 8'd6, s: 1'b1, d: 1'b0, p: 1'b1, data: 16'hBEEF});
    wait_flag_change(20, e);
    exp = sb.pop_front();
    obs = '{lat: 8'(e), s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL press_before_reset: got %h expected %h", obs, exp);
    end
    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    exp = '{lat: 8'd0, s: 1'b0, d: 1'b0, p: 1'b0, data: '0};
    obs = '{lat: 8'd0, s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", obs, exp);
    end
    repeat (2) @(negedge clk);
    switches = 16'h5A5A;
    rst = 1'b0;
    sb.push_back('{lat: 8'd6, s: 1'b1, d: 1'b0, p: 1'b1, data: 16'h5A5A});
    wait_flag_change(20, e);
    exp = sb.pop_front();
    obs = '{lat: 8'(e), s: subiu, d: desceu, p: pressed, data: data_out};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL press_after_reset: got lat=%0d s=%b d=%b p=%b data=%h expected lat=%0d s=%b d=%b p=%b data=%h",
               obs.lat, obs.s, obs.d, obs.p, obs.data, exp.lat, exp.s, exp.d, exp.p, exp.data);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release("release", 1'b1, 1'b1, 16'h00A5);
    test_glitch();
    test_bounce();
    test_release("second_release", 1'b0, 1'b0, 16'h1234);
    test_reset_mid_press();
    test_release("release_after_reset", 1'b1, 1'b1, 16'h5A5A);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_handshake_responder.md
BUTTON_HANDSHAKE_RESPONDER -- requirements
Module: button_handshake_responder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized samples required to accept a level change; legal range >= 1.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning width of switches and data_out.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 button  input  1  raw push-button, asynchronous to clk, 1 = pressed, may bounce.
REQ-006 switches  input  DATA_WIDTH  operand presented by user; quasi-static.
REQ-007 subiu  output  1  press flag; toggles once per accepted press.
REQ-008 desceu  output  1  release flag; toggles once per accepted release.
REQ-009 data_out  output  DATA_WIDTH  switches captured at the accepted press.
REQ-010 pressed  output  1  debounced button level.

Function
REQ-011 SHALL pass button through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 SHALL implement FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: sync2=1 -> PRESS_WAIT with count=1, or directly to HELD if DEBOUNCE_CYCLES=1; else stay.
REQ-014 PRESS_WAIT: sync2=0 -> IDLE, count=0; sync2=1 and count=DEBOUNCE_CYCLES-1 -> HELD, count=0; else count+1.
REQ-015 HELD: sync2=0 -> RELEASE_WAIT with count=1, or directly to IDLE if DEBOUNCE_CYCLES=1; else stay.
REQ-016 RELEASE_WAIT: sync2=1 -> HELD, count=0; sync2=0 and count=DEBOUNCE_CYCLES-1 -> IDLE, count=0; else count+1.
REQ-017 On the edge entering HELD from IDLE/PRESS_WAIT: subiu SHALL invert and data_out SHALL load switches, same edge.
REQ-018 On the edge entering IDLE from HELD/RELEASE_WAIT: desceu SHALL invert; data_out SHALL hold.
REQ-019 pressed SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-020 Invariant: (subiu != desceu) SHALL equal pressed at every cycle; consumer waits for inequality (press), then equality (release).
REQ-021 Latency: raw button stable after a change SHALL produce the flag toggle on the (DEBOUNCE_CYCLES+2)th rising clk edge after the change.
REQ-022 Any sync2 sample opposite to the pending direction SHALL abort the wait and clear count; no partial credit.
REQ-023 Count SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-024 subiu and desceu SHALL never toggle on the same edge; each SHALL toggle at most once per edge.
REQ-025 switches changes outside the press-accept edge SHALL NOT affect data_out.
REQ-026 Flags wrap naturally (1 -> 0 on the next toggle); no press counting beyond the flags.

Reset
REQ-027 rst=1 SHALL immediately force sync1, sync2, count, subiu, desceu, pressed to 0, data_out to 0, FSM to IDLE.
REQ-028 Reset mid-press SHALL leave flags equal (idle); if button is still held after deassertion, a new press SHALL be accepted per REQ-021.
REQ-029 Outputs SHALL hold reset values while rst=1 regardless of button.

Verification (DEBOUNCE_CYCLES=4, DATA_WIDTH=16)
REQ-030 Reset, switches=16'h00A5, button 0->1 held -> subiu=1, pressed=1, data_out=16'h00A5 at 6th edge; desceu=0.
REQ-031 Then switches=16'hFFFF, button 1->0 held -> desceu=1, pressed=0 at 6th edge; data_out stays 16'h00A5.
REQ-032 Button high 3 cycles then low -> no flag toggles, pressed stays 0, data_out unchanged.
REQ-033 Bounce high 2, low 1, then high held -> subiu toggles only after 4 consecutive high sync2 samples (edge 9 from first rise).
REQ-034 Second full press/release after REQ-031 -> subiu 1->0 on press (flags unequal), desceu 1->0 on release (flags equal).
REQ-035 Assert rst while pressed (flags 1/0) -> all outputs 0 asynchronously; release rst with button held -> subiu=1 at 6th edge after deassertion.
